// File: rtl/counter_sched_ctrl_if.sv
// rtl/counter_sched_ctrl_if.sv - config/status bundle for the interval scheduler
interface counter_sched_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int PSW   = 8
);
    logic             start;
    logic             stop;
    logic             mode_periodic;
    logic [WIDTH-1:0] start_val;
    logic [WIDTH-1:0] end_val;
    logic [PSW-1:0]   prescale;
    logic [WIDTH-1:0] count_out;
    logic             busy;
    logic             tick;
    logic             done;

    modport master (
        output start, stop, mode_periodic, start_val, end_val, prescale,
        input  count_out, busy, tick, done
    );

    modport slave (
        input  start, stop, mode_periodic, start_val, end_val, prescale,
        output count_out, busy, tick, done
    );
endinterface

// File: rtl/counter_sched_ctrl.sv
// rtl/counter_sched_ctrl.sv - prescaled one-shot/periodic interval scheduler
module counter_sched_ctrl #(
    parameter int WIDTH = 4,
    parameter int PSW   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    counter_sched_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state, state_nxt;

    logic [WIDTH-1:0] count_q, count_nxt;
    logic [PSW-1:0]   ps_q, ps_nxt;
    logic             tick_q, tick_nxt;
    logic             done_q, done_nxt;
    logic             busy_q, busy_nxt;

    logic [WIDTH-1:0] start_q, end_q;
    logic [PSW-1:0]   prescale_q;
    logic             periodic_q;
    logic             capture;

    logic             advance;
    logic             at_end;

    assign advance = (ps_q == prescale_q);
    assign at_end  = (count_q == end_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start && !bus.stop) state_nxt = LOAD;
            LOAD: state_nxt = bus.stop ? IDLE : RUN;
            RUN: begin
                if (bus.stop) begin
                    state_nxt = IDLE;
                end else if (advance && at_end && !periodic_q) begin
                    state_nxt = DONE;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the datapath and registered outputs; stop suppresses any load/advance.
    always_comb begin
        count_nxt = count_q;
        ps_nxt    = ps_q;
        tick_nxt  = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: capture = bus.start && !bus.stop;
            LOAD: begin
                if (!bus.stop) begin
                    count_nxt = start_q;
                    ps_nxt    = '0;
                end
            end
            RUN: begin
                if (!bus.stop) begin
                    if (advance) begin
                        ps_nxt = '0;
                        if (at_end) begin
                            tick_nxt = 1'b1;
                            if (periodic_q) count_nxt = start_q;
                        end else begin
                            count_nxt = count_q + WIDTH'(1);
                        end
                    end else begin
                        ps_nxt = ps_q + PSW'(1);
                    end
                end
            end
            default: ;
        endcase
        busy_nxt = (state_nxt == LOAD) || (state_nxt == RUN);
        done_nxt = (state_nxt == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q    <= '0;
            ps_q       <= '0;
            tick_q     <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            start_q    <= '0;
            end_q      <= '0;
            prescale_q <= '0;
            periodic_q <= 1'b0;
        end else begin
            count_q <= count_nxt;
            ps_q    <= ps_nxt;
            tick_q  <= tick_nxt;
            done_q  <= done_nxt;
            busy_q  <= busy_nxt;
            if (capture) begin
                start_q    <= bus.start_val;
                end_q      <= bus.end_val;
                prescale_q <= bus.prescale;
                periodic_q <= bus.mode_periodic;
            end
        end
    end

    assign bus.count_out = count_q;
    assign bus.busy      = busy_q;
    assign bus.tick      = tick_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_counter_sched_ctrl.sv
// tb/tb_counter_sched_ctrl.sv - directed self-checking bench for counter_sched_ctrl
module tb_counter_sched_ctrl;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    int   exp_p[8] = '{14, 15, 15, 0, 0, 1, 1, 14};

    counter_sched_ctrl_if #(.WIDTH(4), .PSW(8)) bus ();

    counter_sched_ctrl #(.WIDTH(4), .PSW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.mode_periodic = 1'b0;
        bus.start_val = '0;
        bus.end_val = '0;
        bus.prescale = '0;
        step(2);
        check("rst_count", bus.count_out, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_tick", bus.tick, 0);
        check("rst_done", bus.done, 0);
        rst_n = 1'b1;
        step(1);

        // one-shot 3..5, prescale 0; a start pulse mid-run must be ignored
        bus.start_val = 4'd3; bus.end_val = 4'd5; bus.prescale = 8'd0;
        bus.mode_periodic = 1'b0; bus.start = 1'b1;
        step(1);
        check("os_load_busy", bus.busy, 1);
        bus.start = 1'b0;
        step(1);
        check("os_cnt3", bus.count_out, 3);
        bus.start = 1'b1; bus.start_val = 4'd9;
        step(1);
        check("os_cnt4", bus.count_out, 4);
        check("os_tick_early", bus.tick, 0);
        bus.start = 1'b0;
        step(1);
        check("os_cnt5", bus.count_out, 5);
        check("os_done_early", bus.done, 0);
        step(1);
        check("os_tick", bus.tick, 1);
        check("os_done", bus.done, 1);
        check("os_busy_done", bus.busy, 0);
        check("os_cnt_hold", bus.count_out, 5);
        bus.start = 1'b1;
        step(1);
        check("os_tick_clr", bus.tick, 0);
        check("os_done_clr", bus.done, 0);
        check("os_idle_busy", bus.busy, 0);
        bus.start = 1'b0;
        step(1);
        check("os_no_restart", bus.busy, 0);

        // periodic wrap 14..1, prescale 1; config changes mid-run are shadowed
        bus.start_val = 4'd14; bus.end_val = 4'd1; bus.prescale = 8'd1;
        bus.mode_periodic = 1'b1; bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        step(1);
        check("pw_load", bus.count_out, 14);
        for (int r = 0; r < 2; r++) begin
            for (int k = 1; k <= 8; k++) begin
                if (r == 0 && k == 2) begin
                    bus.end_val = 4'd5;
                    bus.prescale = 8'd0;
                end
                step(1);
                check("pw_cnt", bus.count_out, exp_p[k-1]);
                check("pw_tick", bus.tick, (k == 8) ? 1 : 0);
                check("pw_done", bus.done, 0);
            end
        end

        // stop at count 15
        step(2);
        check("st_pre", bus.count_out, 15);
        bus.stop = 1'b1;
        step(1);
        check("st_busy", bus.busy, 0);
        check("st_cnt", bus.count_out, 15);
        check("st_tick", bus.tick, 0);
        bus.stop = 1'b0;
        step(2);
        check("st_idle_cnt", bus.count_out, 15);
        check("st_idle_busy", bus.busy, 0);

        // start+stop together in IDLE, then start 7..7 prescale 2 periodic
        bus.start_val = 4'd7; bus.end_val = 4'd7; bus.prescale = 8'd2;
        bus.mode_periodic = 1'b1; bus.start = 1'b1; bus.stop = 1'b1;
        step(1);
        check("ss_busy", bus.busy, 0);
        check("ss_cnt", bus.count_out, 15);
        bus.stop = 1'b0;
        step(1);
        check("eq_load_busy", bus.busy, 1);
        bus.start = 1'b0;
        step(1);
        check("eq_cnt", bus.count_out, 7);
        for (int k = 1; k <= 6; k++) begin
            step(1);
            check("eq_cnt_run", bus.count_out, 7);
            check("eq_tick", bus.tick, (k % 3 == 0) ? 1 : 0);
        end

        // reset during RUN
        rst_n = 1'b0;
        step(1);
        check("rr_cnt", bus.count_out, 0);
        check("rr_busy", bus.busy, 0);
        check("rr_tick", bus.tick, 0);
        rst_n = 1'b1;
        step(2);
        check("rr_no_start", bus.busy, 0);

        // reset during DONE
        bus.start_val = 4'd2; bus.end_val = 4'd2; bus.prescale = 8'd0;
        bus.mode_periodic = 1'b0; bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        step(2);
        check("rd_done", bus.done, 1);
        check("rd_cnt_pre", bus.count_out, 2);
        rst_n = 1'b0;
        step(1);
        check("rd_cnt", bus.count_out, 0);
        check("rd_done_clr", bus.done, 0);
        check("rd_busy", bus.busy, 0);
        rst_n = 1'b1;
        step(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
